par_to_serial: RTL
==================

# par_to_serial

Parallel-to-serial transmitter for the physical-layer transmit path. It runs on `clk_8f`, the same fast clock fed to `gen_clk`. It consumes the byte stream produced at the `clk_f` rate by the upstream byte-striping/mux stages and serializes each byte MSB-first onto a single line. Before carrying data it sends a training sequence of COM characters (`8'hBC`), and it sends COM whenever no valid byte is offered.

## Interface
Parameters:
- `TRAIN_COMS`, default 4: number of COM characters sent in training after reset or re-enable; legal range 1..15.

Ports:
- `clk_8f`  input  1  bit clock; every register updates on its rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `enb`  input  1  enable, sampled synchronously; low forces the OFF state.
- `data_in`  input  8  parallel byte offered by the upstream stage.
- `valid_in`  input  1  `data_in` holds a real data byte.
- `in_ready`  output  1  combinational; high when this edge loads from `data_in`.
- `data_out`  output  1  serial bit, driven from shift-register bit 7.
- `link_up`  output  1  registered; high while in ACTIVE.

## Operation
- Registers:
  - `bit_cnt[2:0]`.
  - `sr[7:0]` shift register; `data_out = sr[7]`.
  - `com_cnt[3:0]`.
  - `state` ∈ {OFF, TRAIN, ACTIVE}.
- Reset values: `state`=TRAIN, `bit_cnt`=7, `com_cnt`=0, `sr`=0, so `data_out`=0 and `link_up`=0.
- A load edge is any edge with `enb`=1 and `bit_cnt`==7.
- Every enabled edge: `bit_cnt` ← `bit_cnt`+1, wrapping 7→0. On non-load edges, `sr` ← {`sr[6:0]`,0}.
- On a load edge:
  - OFF: `sr` ← `8'hBC`, `com_cnt` ← 1, `state` ← TRAIN. If `TRAIN_COMS`==1, `state` ← ACTIVE instead.
  - TRAIN: `sr` ← `8'hBC`, `com_cnt` ← `com_cnt`+1. When `com_cnt`==`TRAIN_COMS`-1, `state` ← ACTIVE and `link_up` ← 1.
  - ACTIVE: if `valid_in`, `sr` ← `data_in`; otherwise `sr` ← `8'hBC`.
- `in_ready` = (`state`==ACTIVE) && (`bit_cnt`==7) && `enb`. A byte is consumed only when `in_ready` && `valid_in` are both high at the same edge.
- `valid_in` outside a load edge is ignored. Upstream must hold the byte until it sees `in_ready`.
- `enb`=0 at any edge, including mid-byte: `state` ← OFF, `bit_cnt` ← 7, `com_cnt` ← 0, `sr` ← 0, `link_up` ← 0. The partial byte is discarded.
- `enb` returning high: the first edge is a load edge (OFF path above), so training restarts in full.
- `rst` asserted mid-byte: all registers clear immediately, without waiting for a clock edge.

## Timing
- Frame period: exactly 8 `clk_8f` cycles; load edges are 8 cycles apart.
- Latency: a byte loaded at edge E puts its bit 7 on `data_out` right after E. Bit k appears after edge E+(7−k); bit 0 holds until E+8.
- First load edge after reset release is the first enabled rising edge.
- Training occupies `TRAIN_COMS`×8 cycles. `link_up` rises at the load edge of the last training COM. The first `in_ready` comes at the following load edge.
- `in_ready` changes only on clock edges and `enb`; it has no combinational path from `valid_in` or `data_in`.

## Configuration
- Macro `P2S_TX_CNT_EN`:
  - Defined: adds output `tx_byte_cnt[15:0]`. Reset value 0; it increments on every consumed data byte (not COM), saturates at `16'hFFFF`, and clears when `enb`=0.
  - Undefined: the port and counter do not exist; all other behaviour is identical.

## Structure
- Shared package `p2s_pkg`:
  - `COM_CHAR` = `8'hBC`.
  - State enum {OFF, TRAIN, ACTIVE}.
  - `FRAME_BITS` = 8.
- Sub-module `p2s_shifter`: 8-bit load/shift register with `load`, `shift`, `clear` controls and `msb` output.
- The top level holds the counters, the FSM and the optional statistics counter.

## Test plan
- Reset, `enb`=1, `TRAIN_COMS`=4, `valid_in`=0 → `data_out` repeats 1,0,1,1,1,1,0,0 four times. `link_up` rises at edge 24. The first `in_ready` pulse comes at edge 32, then every 8 cycles.
- After training, `data_in`=`8'hA5` with `valid_in`=1 at the load edge → next 8 bits are 1,0,1,0,0,1,0,1. The following frame is COM if `valid_in` has dropped.
- Back-to-back bytes `8'h00`, `8'hFF`, `8'h3C` → continuous 24-bit stream, with exactly one `in_ready` per byte and no gaps.
- `enb` dropped at bit 3 of a data byte → `data_out`=0 and `link_up`=0 on the next edge. On re-enable, 4 COMs are sent before `in_ready` is asserted again.
- `rst` pulsed asynchronously between edges mid-frame → all outputs read 0 immediately. Training restarts at the first edge after release.
- With `P2S_TX_CNT_EN` defined: 3 data bytes interleaved with 2 COM frames → `tx_byte_cnt`=3. Preloading the counter to `16'hFFFE` and sending 3 bytes → it holds at `16'hFFFF`.

Source files
------------

// File: rtl/p2s_pkg.sv
// Shared constants and state encoding for the parallel-to-serial transmitter.
package p2s_pkg;
  localparam logic [7:0] COM_CHAR   = 8'hBC;
  localparam int         FRAME_BITS = 8;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    TRAIN  = 2'd1,
    ACTIVE = 2'd2
  } p2s_state_e;
endpackage

// File: rtl/p2s_shifter.sv
// Frame-wide load/shift register; MSB is the serial line.
module p2s_shifter
  import p2s_pkg::*;
(
  input  logic                  clk_8f,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  clear,
  input  logic [FRAME_BITS-1:0] din,
  output logic                  msb
);
  logic [FRAME_BITS-1:0] sr_q, sr_d;

  // clear beats load beats shift
  always_comb begin
    sr_d = sr_q;
    if (clear)      sr_d = '0;
    else if (load)  sr_d = din;
    else if (shift) sr_d = {sr_q[FRAME_BITS-2:0], 1'b0};
  end

  always_ff @(posedge clk_8f or posedge rst) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  assign msb = sr_q[FRAME_BITS-1];
endmodule

// File: rtl/par_to_serial.sv
// Byte-to-serial transmitter with COM training and idle fill.
// Define P2S_TX_CNT_EN to add the saturating tx_byte_cnt statistics output.
module par_to_serial
  import p2s_pkg::*;
#(
  parameter int TRAIN_COMS = 4
) (
  input  logic        clk_8f,
  input  logic        rst,
  input  logic        enb,
  input  logic [7:0]  data_in,
  input  logic        valid_in,
  output logic        in_ready,
  output logic        data_out,
`ifdef P2S_TX_CNT_EN
  output logic [15:0] tx_byte_cnt,
`endif
  output logic        link_up
);
  localparam logic [3:0] LAST_COM = 4'(TRAIN_COMS - 1);

  p2s_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] com_cnt_q, com_cnt_d;
  logic       link_up_q, link_up_d;
  logic       load_edge;
  logic [7:0] sr_din;

  assign load_edge = enb && (bit_cnt_q == 3'd7);
  assign in_ready  = load_edge && (state_q == ACTIVE);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    com_cnt_d = com_cnt_q;
    sr_din    = COM_CHAR;
    if (!enb) begin
      state_d   = OFF;
      bit_cnt_d = 3'd7;
      com_cnt_d = 4'd0;
    end else begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (load_edge) begin
        case (state_q)
          OFF: begin
            com_cnt_d = 4'd1;
            state_d   = (TRAIN_COMS == 1) ? ACTIVE : TRAIN;
          end
          TRAIN: begin
            com_cnt_d = com_cnt_q + 4'd1;
            if (com_cnt_q == LAST_COM) state_d = ACTIVE;
          end
          ACTIVE: if (valid_in) sr_din = data_in;
          default: state_d = OFF;
        endcase
      end
    end
    link_up_d = (state_d == ACTIVE);
  end

  always_ff @(posedge clk_8f or posedge rst) begin
    if (rst) begin
      state_q   <= TRAIN;
      bit_cnt_q <= 3'd7;
      com_cnt_q <= 4'd0;
      link_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      link_up_q <= link_up_d;
    end
  end

  assign link_up = link_up_q;

  p2s_shifter u_shifter (
    .clk_8f (clk_8f),
    .rst    (rst),
    .load   (load_edge),
    .shift  (enb && !load_edge),
    .clear  (!enb),
    .din    (sr_din),
    .msb    (data_out)
  );

`ifdef P2S_TX_CNT_EN
  logic [15:0] tx_cnt_q, tx_cnt_d;

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    if (!enb)                                             tx_cnt_d = 16'd0;
    else if (in_ready && valid_in && tx_cnt_q != 16'hFFFF) tx_cnt_d = tx_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_8f or posedge rst) begin
    if (rst) tx_cnt_q <= 16'd0;
    else     tx_cnt_q <= tx_cnt_d;
  end

  assign tx_byte_cnt = tx_cnt_q;
`endif
endmodule
